// File: rtl/bnn_pkg.sv
// Shared defaults and width helpers for the binarised serial neuron.
package bnn_pkg;

  localparam int DEF_INPUTS    = 8;
  localparam int DEF_BEATS     = 4;
  localparam int DEF_BIAS_BITS = 6;
  localparam int DEF_XNOR      = 1;

  // Bits needed to hold a count in 0..n.
  function automatic int acc_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index beats 0..beats-1, never narrower than one bit.
  function automatic int cnt_width(input int beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/popcount.sv
// Combinational population count of one beat of synapse bits.
module popcount
  import bnn_pkg::*;
#(
  parameter int INPUTS = DEF_INPUTS,
  parameter int CW     = acc_width(INPUTS)
) (
  input  logic [INPUTS-1:0] bits,
  output logic [CW-1:0]     count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < INPUTS; i++)
      count = count + CW'(bits[i]);
  end

endmodule

// File: rtl/serial_neuron.sv
// Bit-serial-loaded binary neuron: accumulates synapse popcounts over BEATS
// beats and thresholds the total against a loadable bias.
module serial_neuron
  import bnn_pkg::*;
#(
  parameter int INPUTS    = DEF_INPUTS,
  parameter int BEATS     = DEF_BEATS,
  parameter int BIAS_BITS = DEF_BIAS_BITS,
  parameter int XNOR      = DEF_XNOR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              setup,
  input  logic              param_in,
  output logic              param_out,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INPUTS-1:0] inputs,
  output logic              out_valid,
  output logic              axon
);

  localparam int N  = INPUTS * BEATS;
  localparam int P  = N + BIAS_BITS;
  localparam int AW = acc_width(N);
  localparam int CW = cnt_width(BEATS);
  localparam int PW = acc_width(INPUTS);
  localparam int MW = (AW > BIAS_BITS) ? AW : BIAS_BITS;

  logic [P-1:0]                   param_q;
  logic [AW-1:0]                  acc_q;
  logic [CW-1:0]                  cnt_q;

  logic [BEATS-1:0][INPUTS-1:0]   w_beats;
  logic [BIAS_BITS-1:0]           bias;
  logic [INPUTS-1:0]              w_sel;
  logic [INPUTS-1:0]              syn;
  logic [PW-1:0]                  pc;
  logic [AW-1:0]                  sum;
  logic                           fire;
  logic                           last_beat;
  logic                           accept;

  assign w_beats   = param_q[N-1:0];
  assign bias      = param_q[P-1 -: BIAS_BITS];
  assign w_sel     = w_beats[cnt_q];
  assign param_out = param_q[P-1];
  assign in_ready  = !setup;
  assign accept    = in_valid && !setup;

  for (genvar i = 0; i < INPUTS; i++) begin : g_syn
    if (XNOR != 0) begin : g_xnor
      assign syn[i] = ~(inputs[i] ^ w_sel[i]);
    end else begin : g_and
      assign syn[i] = inputs[i] & w_sel[i];
    end
  end

  popcount #(.INPUTS(INPUTS), .CW(PW)) u_pop (
    .bits  (syn),
    .count (pc)
  );

  // acc never exceeds N - INPUTS before the final beat, so AW bits suffice.
  assign sum       = acc_q + AW'(pc);
  assign fire      = MW'(sum) > MW'(bias);
  assign last_beat = (cnt_q == CW'(BEATS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      param_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      axon      <= 1'b0;
    end else if (setup) begin
      // Loading aborts any partial vector; axon keeps its last decision.
      param_q   <= {param_q[P-2:0], param_in};
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (last_beat) begin
          axon      <= fire;
          out_valid <= 1'b1;
          acc_q     <= '0;
          cnt_q     <= '0;
        end else begin
          acc_q <= sum;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_neuron.sv
// Scoreboard bench for serial_neuron: XNOR pair in a param chain plus an AND-mode copy.
module tb_serial_neuron;

  localparam int P = 38;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic setup = 1'b0;
  logic param_in = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] inputs = '0;

  logic a_param_out, a_in_ready, a_out_valid, a_axon;
  logic b_param_out, b_in_ready, b_out_valid, b_axon;
  logic c_param_out, c_in_ready, c_out_valid, c_axon;

  int n_cmp = 0;
  int n_err = 0;
  int pulses_a = 0;
  int pulses_c = 0;
  bit en_a = 1'b1;
  bit en_c = 1'b0;
  logic q_a[$];
  logic q_c[$];
  logic [P-1:0] shadow = '0;

  always #5 clk = ~clk;

  serial_neuron #(.INPUTS(8), .BEATS(4), .BIAS_BITS(6), .XNOR(1)) u_a (
    .clk(clk), .reset(reset), .setup(setup), .param_in(param_in),
    .param_out(a_param_out), .in_valid(in_valid), .in_ready(a_in_ready),
    .inputs(inputs), .out_valid(a_out_valid), .axon(a_axon));

  serial_neuron #(.INPUTS(8), .BEATS(4), .BIAS_BITS(6), .XNOR(1)) u_b (
    .clk(clk), .reset(reset), .setup(setup), .param_in(a_param_out),
    .param_out(b_param_out), .in_valid(in_valid), .in_ready(b_in_ready),
    .inputs(inputs), .out_valid(b_out_valid), .axon(b_axon));

  serial_neuron #(.INPUTS(8), .BEATS(4), .BIAS_BITS(6), .XNOR(0)) u_c (
    .clk(clk), .reset(reset), .setup(setup), .param_in(param_in),
    .param_out(c_param_out), .in_valid(in_valid), .in_ready(c_in_ready),
    .inputs(inputs), .out_valid(c_out_valid), .axon(c_axon));

  // Scoreboard pops: every out_valid pulse must match the oldest expected decision.
  always @(negedge clk) begin : mon_a
    logic e;
    if (en_a && a_out_valid) begin
      pulses_a++;
      n_cmp++;
      if (q_a.size() == 0) begin
        n_err++;
        $display("FAIL spurious_a: out_valid=1 with no expected result queued");
      end else begin
        e = q_a.pop_front();
        if (a_axon !== e) begin
          n_err++;
          $display("FAIL axon_a: got %b expected %b", a_axon, e);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_c
    logic e;
    if (en_c && c_out_valid) begin
      pulses_c++;
      n_cmp++;
      if (q_c.size() == 0) begin
        n_err++;
        $display("FAIL spurious_c: out_valid=1 with no expected result queued");
      end else begin
        e = q_c.pop_front();
        if (c_axon !== e) begin
          n_err++;
          $display("FAIL axon_c: got %b expected %b", c_axon, e);
        end
      end
    end
  end

  function automatic logic model(input logic [P-1:0] p, input logic [3:0][7:0] d, input bit xn);
    int c;
    logic w, x;
    c = 0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++) begin
        w = p[b*8+i];
        x = d[b][i];
        c += (xn ? (w == x) : (w && x)) ? 1 : 0;
      end
    return c > int'(p[P-1:32]);
  endfunction

  function automatic logic [3:0][7:0] vec4(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [P-1:0] v);
    setup = 1'b1;
    for (int i = P - 1; i >= 0; i--) begin
      param_in = v[i];
      tick();
    end
    setup = 1'b0;
    param_in = 1'b0;
    shadow = v;
  endtask

  task automatic send_vec(input logic [3:0][7:0] d, input int gap);
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1;
      inputs = d[b];
      tick();
      if (gap > 0 && b < 3) begin
        in_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (a_axon !== 1'b0) begin n_err++; $display("FAIL reset_axon: got %b expected 0", a_axon); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    n_cmp++; if (u_a.param_q !== '0) begin n_err++; $display("FAIL reset_param: got %h expected 0", u_a.param_q); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load();
    logic [3:0][7:0] d;
    d = vec4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    setup = 1'b1;
    #1;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL setup_in_ready: got %b expected 0", a_in_ready); end
    load({6'd31, 32'hFFFF_FFFF});
    n_cmp++; if (a_param_out !== 1'b0) begin n_err++; $display("FAIL load_param_out: got %b expected 0", a_param_out); end
    q_a.push_back(model(shadow, d, 1'b1));
    send_vec(d, 0);
    n_cmp++; if (a_out_valid !== 1'b1 || a_axon !== 1'b1) begin
      n_err++; $display("FAIL load_b31_latency: got ov=%b axon=%b expected ov=1 axon=1", a_out_valid, a_axon); end
    tick();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL pulse_width: got %b expected 0", a_out_valid); end
    load({6'd32, 32'hFFFF_FFFF});
    n_cmp++; if (a_axon !== 1'b1) begin n_err++; $display("FAIL axon_hold_setup: got %b expected 1", a_axon); end
    q_a.push_back(model(shadow, d, 1'b1));
    send_vec(d, 0);
    n_cmp++; if (a_out_valid !== 1'b1 || a_axon !== 1'b0) begin
      n_err++; $display("FAIL load_b32: got ov=%b axon=%b expected ov=1 axon=0", a_out_valid, a_axon); end
    tick();
  endtask

  task automatic test_back_to_back();
    load({6'd0, 32'h0000_0000});
    q_a.push_back(model(shadow, vec4(8'h00, 8'h00, 8'h00, 8'h00), 1'b1));
    q_a.push_back(model(shadow, vec4(8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b1));
    q_a.push_back(model(shadow, vec4(8'h00, 8'hFF, 8'hFF, 8'hFF), 1'b1));
    send_vec(vec4(8'h00, 8'h00, 8'h00, 8'h00), 0);
    send_vec(vec4(8'hFF, 8'hFF, 8'hFF, 8'hFF), 0);
    send_vec(vec4(8'h00, 8'hFF, 8'hFF, 8'hFF), 0);
    tick(); tick();
    n_cmp++; if (q_a.size() != 0) begin n_err++; $display("FAIL b2b_drain: got %0d pending expected 0", q_a.size()); end
  endtask

  task automatic test_and_mode();
    en_a = 1'b0;
    en_c = 1'b1;
    load({6'd3, 32'hFFFF_FFFF});
    for (int g = 0; g <= 3; g += 3) begin
      q_c.push_back(model(shadow, vec4(8'h01, 8'h01, 8'h01, 8'h01), 1'b0));
      send_vec(vec4(8'h01, 8'h01, 8'h01, 8'h01), g);
      q_c.push_back(model(shadow, vec4(8'h01, 8'h01, 8'h01, 8'h00), 1'b0));
      send_vec(vec4(8'h01, 8'h01, 8'h01, 8'h00), g);
    end
    tick(); tick();
    n_cmp++; if (pulses_c != 4) begin n_err++; $display("FAIL and_pulses: got %0d expected 4", pulses_c); end
    n_cmp++; if (q_c.size() != 0) begin n_err++; $display("FAIL and_drain: got %0d pending expected 0", q_c.size()); end
    en_c = 1'b0;
    en_a = 1'b1;
  endtask

  task automatic test_bias_bounds();
    load({6'd33, 32'hFFFF_FFFF});
    q_a.push_back(model(shadow, vec4(8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b1));
    send_vec(vec4(8'hFF, 8'hFF, 8'hFF, 8'hFF), 0);
    load({6'd63, 32'hFFFF_FFFF});
    q_a.push_back(model(shadow, vec4(8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b1));
    send_vec(vec4(8'hFF, 8'hFF, 8'hFF, 8'hFF), 0);
    load({6'd0, 32'hFFFF_FFFF});
    q_a.push_back(model(shadow, vec4(8'h00, 8'h00, 8'h10, 8'h00), 1'b1));
    send_vec(vec4(8'h00, 8'h00, 8'h10, 8'h00), 1);
    q_a.push_back(model(shadow, vec4(8'h00, 8'h00, 8'h00, 8'h00), 1'b1));
    send_vec(vec4(8'h00, 8'h00, 8'h00, 8'h00), 0);
    tick(); tick();
    n_cmp++; if (q_a.size() != 0) begin n_err++; $display("FAIL bias_drain: got %0d pending expected 0", q_a.size()); end
  endtask

  task automatic test_abort();
    int p0;
    load({6'd10, 32'h7FFF_FFFF});
    p0 = pulses_a;
    in_valid = 1'b1;
    inputs = 8'hFF;
    tick(); tick();
    setup = 1'b1;
    param_in = 1'b1;
    tick();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL abort_ov: got %b expected 0", a_out_valid); end
    setup = 1'b0;
    in_valid = 1'b0;
    param_in = 1'b0;
    shadow = {shadow[P-2:0], 1'b1};
    q_a.push_back(model(shadow, vec4(8'hFF, 8'h0F, 8'h00, 8'h0F), 1'b1));
    send_vec(vec4(8'hFF, 8'h0F, 8'h00, 8'h0F), 0);
    n_cmp++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL abort_first_ov: got %b expected 1", a_out_valid); end
    q_a.push_back(model(shadow, vec4(8'hFF, 8'hFF, 8'h1F, 8'h00), 1'b1));
    send_vec(vec4(8'hFF, 8'hFF, 8'h1F, 8'h00), 0);
    tick(); tick();
    n_cmp++; if (pulses_a - p0 != 2) begin n_err++; $display("FAIL abort_pulses: got %0d expected 2", pulses_a - p0); end
    n_cmp++; if (q_a.size() != 0) begin n_err++; $display("FAIL abort_drain: got %0d pending expected 0", q_a.size()); end
  endtask

  task automatic test_chain();
    logic [75:0] cv;
    cv = {12'($urandom), $urandom, $urandom};
    setup = 1'b1;
    for (int i = 75; i >= 0; i--) begin
      param_in = cv[i];
      tick();
    end
    setup = 1'b0;
    param_in = 1'b0;
    n_cmp++; if (u_b.param_q !== cv[75:38]) begin n_err++; $display("FAIL chain_b: got %h expected %h", u_b.param_q, cv[75:38]); end
    n_cmp++; if (u_a.param_q !== cv[37:0]) begin n_err++; $display("FAIL chain_a: got %h expected %h", u_a.param_q, cv[37:0]); end
    n_cmp++; if (b_param_out !== cv[75]) begin n_err++; $display("FAIL chain_out: got %b expected %b", b_param_out, cv[75]); end
    shadow = cv[37:0];
  endtask

  task automatic test_async_reset();
    load({6'd5, 32'h0000_0000});
    q_a.push_back(model(shadow, vec4(8'h00, 8'h00, 8'h00, 8'h00), 1'b1));
    send_vec(vec4(8'h00, 8'h00, 8'h00, 8'h00), 0);
    tick();
    in_valid = 1'b1;
    inputs = 8'h00;
    tick(); tick();
    in_valid = 1'b0;
    n_cmp++; if (u_a.acc_q !== 6'd16) begin n_err++; $display("FAIL pre_reset_acc: got %0d expected 16", u_a.acc_q); end
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (a_axon !== 1'b0 || a_out_valid !== 1'b0) begin
      n_err++; $display("FAIL async_out: got axon=%b ov=%b expected 0 0", a_axon, a_out_valid); end
    n_cmp++; if (u_a.param_q !== '0 || u_a.acc_q !== '0 || u_a.cnt_q !== '0) begin
      n_err++; $display("FAIL async_regs: got p=%h acc=%0d cnt=%0d expected 0", u_a.param_q, u_a.acc_q, u_a.cnt_q); end
    #2 reset = 1'b0;
    shadow = '0;
    q_a.push_back(model(shadow, vec4(8'h00, 8'h00, 8'h00, 8'h00), 1'b1));
    send_vec(vec4(8'h00, 8'h00, 8'h00, 8'h00), 0);
    n_cmp++; if (a_out_valid !== 1'b1 || a_axon !== 1'b1) begin
      n_err++; $display("FAIL post_reset_eval: got ov=%b axon=%b expected 1 1", a_out_valid, a_axon); end
    tick(); tick();
    n_cmp++; if (q_a.size() != 0) begin n_err++; $display("FAIL reset_drain: got %0d pending expected 0", q_a.size()); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_and_mode();
    test_bias_bounds();
    test_abort();
    test_chain();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
